// File: rtl/rv_pkg.sv
// Shared defaults and output-stage state encoding for the ready/valid transmitter.
package rv_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int DEPTH_DEF  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_t;

endpackage

// File: rtl/rv_fifo.sv
// Power-of-two circular buffer with wrapping pointers and a registered full flag.
module rv_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [PTR_W:0]    count_reg;
   logic [PTR_W:0]    count_next;
   logic              full_reg;
   logic              push_ok;
   logic              pop_ok;

   // Pushes while full are dropped here so the caller cannot corrupt the buffer.
   assign push_ok = push && !full_reg;
   assign pop_ok  = pop && (count_reg != '0);

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop_ok)
         count_next = count_reg + 1'b1;
      else if (!push_ok && pop_ok)
         count_next = count_reg - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         full_reg  <= (count_next == FULL_CNT);
      end
   end

   // Storage carries no reset; only pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= din;
   end

   assign dout  = mem[rd_ptr_reg];
   assign full  = full_reg;
   assign empty = (count_reg == '0);

endmodule

// File: rtl/rv_transmitter.sv
// Buffered ready/valid transmitter: FIFO feeding a registered output stage,
// with a transfer counter and a sticky overflow flag.
module rv_transmitter
   import rv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              valid,
   input  logic              ready,
   output logic [DATA_W-1:0] data_out,
   output logic              tx_done,
   output logic [15:0]       tx_count,
   output logic              err_ovf
);

   tx_state_t         state_reg;
   logic              valid_reg;
   logic [DATA_W-1:0] data_out_reg;
   logic [15:0]       tx_count_reg;
   logic              err_ovf_reg;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   // The output register frees up either when empty (IDLE) or on a handshake.
   assign fifo_pop = !fifo_empty && ((state_reg == IDLE) || ready);

   rv_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_en),
      .pop   (fifo_pop),
      .din   (wr_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         valid_reg    <= 1'b0;
         data_out_reg <= '0;
         tx_count_reg <= '0;
         err_ovf_reg  <= 1'b0;
      end else begin
         if (wr_en && fifo_full)
            err_ovf_reg <= 1'b1;
         if (tx_done)
            tx_count_reg <= tx_count_reg + 16'd1;
         case (state_reg)
            IDLE: begin
               if (!fifo_empty) begin
                  data_out_reg <= fifo_dout;
                  valid_reg    <= 1'b1;
                  state_reg    <= SEND;
               end
            end
            SEND: begin
               if (ready) begin
                  if (!fifo_empty) begin
                     data_out_reg <= fifo_dout;
                  end else begin
                     valid_reg <= 1'b0;
                     state_reg <= IDLE;
                  end
               end
            end
            default: begin
               valid_reg <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign full     = fifo_full;
   assign valid    = valid_reg;
   assign data_out = data_out_reg;
   assign tx_done  = valid_reg && ready;
   assign tx_count = tx_count_reg;
   assign err_ovf  = err_ovf_reg;

endmodule

// File: tb/tb_rv_transmitter.sv
// Directed and randomized bench for rv_transmitter against a queue-based model
// of the DEPTH+1 word in-order buffer.
module tb_rv_transmitter;

   localparam int DATA_W = 64;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              full;
   logic              valid;
   logic              ready = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic              tx_done;
   logic [15:0]       tx_count;
   logic              err_ovf;

   rv_transmitter #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .valid    (valid),
      .ready    (ready),
      .data_out (data_out),
      .tx_done  (tx_done),
      .tx_count (tx_count),
      .err_ovf  (err_ovf)
   );

   always #5 clk = ~clk;

   int                checks   = 0;
   int                failures = 0;
   logic [DATA_W-1:0] q [$];
   logic [15:0]       exp_count = '0;
   logic              exp_ovf   = 1'b0;
   logic              prev_valid = 1'b0;
   logic              prev_ready = 1'b0;
   logic [DATA_W-1:0] prev_data  = '0;
   bit                quiet = 1'b0;

   function automatic void check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endfunction

   function automatic void model_reset();
      q.delete();
      exp_count  = '0;
      exp_ovf    = 1'b0;
      prev_valid = 1'b0;
   endfunction

   // One clock with inputs already driven: compare at the falling edge, advance
   // the model for the coming rising edge, then return just after that edge.
   task automatic cycle();
      int total;
      @(negedge clk);
      total = q.size();
      check("full", full, 64'(total == DEPTH + 1));
      check("tx_done", tx_done, 64'(valid && ready));
      check("tx_count", tx_count, exp_count);
      check("err_ovf", err_ovf, exp_ovf);
      if (prev_valid && !prev_ready) begin
         check("valid_hold", valid, 1);
         check("data_hold", data_out, prev_data);
      end
      if (valid && ready) begin
         if (q.size() == 0) begin
            check("stale_word", 1, 0);
         end else begin
            if (!quiet)
               $display("xfer #%0d data=%h expected=%h", exp_count + 16'd1, data_out, q[0]);
            check("hs_data", data_out, q[0]);
            void'(q.pop_front());
         end
         exp_count++;
      end
      if (wr_en) begin
         if (total == DEPTH + 1)
            exp_ovf = 1'b1;
         else
            q.push_back(wr_data);
      end
      prev_valid = valid;
      prev_ready = ready;
      prev_data  = data_out;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      #2;
      check("rst_valid", valid, 0);
      check("rst_data", data_out, 0);
      check("rst_full", full, 0);
      check("rst_count", tx_count, 0);
      check("rst_ovf", err_ovf, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();

      // Single word held without ready, then released.
      wr_en = 1'b1;
      wr_data = 64'hDEADBEEFCAFEBABE;
      cycle();
      wr_en = 1'b0;
      check("valid_edge1", valid, 0);
      cycle();
      check("valid_edge2", valid, 1);
      check("first_data", data_out, 64'hDEADBEEFCAFEBABE);
      repeat (10) cycle();
      ready = 1'b1;
      cycle();
      check("count_one", tx_count, 1);
      check("valid_fall", valid, 0);
      check("done_pulse", tx_done, 0);

      // Back-to-back stream.
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1'b1;
         wr_data = 64'(i);
         cycle();
      end
      wr_en = 1'b0;
      repeat (4) cycle();
      check("stream_count", tx_count, 6);
      check("stream_drained", q.size(), 0);

      // Fill to DEPTH+1 with the receiver stalled, then overflow once.
      ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1;
         wr_data = 64'h100 + 64'(i);
         cycle();
         if (i == 4)
            check("full_after5", full, 1);
      end
      wr_en = 1'b0;
      check("ovf_set", err_ovf, 1);
      ready = 1'b1;
      repeat (8) cycle();
      check("ovf_drained", q.size(), 0);
      check("ovf_count", tx_count, 11);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         ready   = ($urandom_range(0, 3) != 0);
         wr_data = {$urandom, $urandom};
         cycle();
      end
      wr_en = 1'b0;
      ready = 1'b1;
      repeat (DEPTH + 3) cycle();
      check("rand_drained", q.size(), 0);

      // Reset mid-transfer with three words queued behind the output register.
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1;
         wr_data = 64'h200 + 64'(i);
         cycle();
      end
      wr_en = 1'b0;
      check("pre_rst_valid", valid, 1);
      #2;
      reset = 1'b0;
      #1;
      check("async_valid", valid, 0);
      check("async_data", data_out, 0);
      check("async_full", full, 0);
      check("async_count", tx_count, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("no_stale", valid, 0);
      end

      // Counter wrap.
      quiet = 1'b1;
      wr_en = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         wr_data = 64'(i);
         cycle();
      end
      wr_en = 1'b0;
      repeat (3) cycle();
      check("count_ffff", tx_count, 16'hFFFF);
      wr_en = 1'b1;
      wr_data = 64'h5A5A;
      cycle();
      wr_en = 1'b0;
      repeat (3) cycle();
      check("count_wrap", tx_count, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
